// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory:
// access size codes, read FSM states and the alignment rule.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    // Illegal size is folded in so callers see a single error flag.
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = off[0];
            SZ_WORD: misaligned = |off;
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the pipeline and the 32-bit storage word:
// store enables/replication and load extraction/extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        uns_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wd_i;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wd_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wd_i[15:0]}};
            end
            SZ_WORD: be_o = 4'b1111;
            default: be_o = 4'b0000;
        endcase
    end

    always_comb begin
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (size_i)
            SZ_BYTE: rdata_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: rdata_o = {{16{~uns_i & half_sel[15]}}, half_sel};
            default: rdata_o = word_i;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed MEM-stage data memory with configurable read latency
// and a Ready/RdValid handshake; stores commit at the accept edge.
module data_memory
    import mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int READ_LAT    = 1
)
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        MemSize,
    input  logic              MemUnsigned,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Wd,
    output logic              Ready,
    output logic [DATA_W-1:0] Rd,
    output logic              RdValid,
    output logic              AddrErr
);

    localparam int IW = $clog2(DEPTH_WORDS);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              rdv_q, rdv_d;
    logic              aerr_q, aerr_d;

    logic [IW-1:0]     idx;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic [31:0]       load_val;
    logic              bad;
    logic              req;
    logic              rd_acc;
    logic              wr_en;
    logic              unused_addr;

    assign unused_addr = ^Addr[ADDR_W-1:IW+2];

    assign idx    = Addr[IW+1:2];
    assign Ready  = (state_q == IDLE);
    assign req    = Ready & (MemRead | MemWrite);
    assign bad    = (MemRead & MemWrite) | misaligned(MemSize, Addr[1:0]);
    assign rd_acc = Ready & MemRead & ~MemWrite;
    assign wr_en  = Ready & MemWrite & ~MemRead & ~bad & ~Rst;

    mem_lane_align u_align (
        .size_i  (MemSize),
        .off_i   (Addr[1:0]),
        .uns_i   (MemUnsigned),
        .wd_i    (Wd),
        .word_i  (mem_q[idx]),
        .be_o    (be),
        .wdata_o (wdata),
        .rdata_o (rdata)
    );

    assign load_val = bad ? '0 : rdata;

    // Storage is deliberately left out of reset.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            for (int l = 0; l < 4; l++) begin
                if (be[l]) mem_q[idx][8*l +: 8] <= wdata[8*l +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        rd_d    = rd_q;
        rdv_d   = 1'b0;
        aerr_d  = req & bad;
        unique case (state_q)
            IDLE: begin
                if (rd_acc) begin
                    if (READ_LAT == 1) begin
                        rd_d  = load_val;
                        rdv_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 3'(READ_LAT - 1);
                        pend_d  = load_val;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd1) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                    rd_d    = pend_q;
                    rdv_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            pend_q  <= '0;
            rd_q    <= '0;
            rdv_q   <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            rd_q    <= rd_d;
            rdv_q   <= rdv_d;
            aerr_q  <= aerr_d;
        end
    end

    assign Rd      = rd_q;
    assign RdValid = rdv_q;
    assign AddrErr = aerr_q;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench: two instances (READ_LAT 1 and 3) driven by random and
// directed requests, checked against a byte-array reference model.
module tb_data_memory;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req, wr_req;
    int          sel;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wd;

    logic        mr0, mw0, mr1, mw1;
    logic        rdy0, rv0, ae0, rdy1, rv1, ae1;
    logic [31:0] rdo0, rdo1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic in_rst = 1'b1;

    exp_t rq0[$], rq1[$];
    int   eq0[$], eq1[$];
    logic [7:0] mm [2][1024];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        in_rst <= rst;
    end

    assign mr0 = rd_req && (sel == 0);
    assign mw0 = wr_req && (sel == 0);
    assign mr1 = rd_req && (sel == 1);
    assign mw1 = wr_req && (sel == 1);

    data_memory #(.READ_LAT(LAT0)) dut0 (
        .Clk(clk), .Rst(rst), .MemRead(mr0), .MemWrite(mw0),
        .MemSize(size), .MemUnsigned(uns), .Addr(addr), .Wd(wd),
        .Ready(rdy0), .Rd(rdo0), .RdValid(rv0), .AddrErr(ae0)
    );

    data_memory #(.READ_LAT(LAT1)) dut1 (
        .Clk(clk), .Rst(rst), .MemRead(mr1), .MemWrite(mw1),
        .MemSize(size), .MemUnsigned(uns), .Addr(addr), .Wd(wd),
        .Ready(rdy1), .Rd(rdo1), .RdValid(rv1), .AddrErr(ae1)
    );

    function automatic bit bad_req(logic [1:0] sz, logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
               (sz == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic int nbytes(logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(int k, logic [1:0] sz,
                                             bit u, logic [31:0] a);
        logic [31:0] v = 32'd0;
        int n = nbytes(sz);
        int base = int'(a[9:0]);
        if (bad_req(sz, a)) return 32'd0;
        for (int i = 0; i < n; i++)
            v = v | (32'(mm[k][base+i]) << (8*i));
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic ref_store(int k, logic [1:0] sz, logic [31:0] a,
                             logic [31:0] d);
        int base = int'(a[9:0]);
        for (int i = 0; i < nbytes(sz); i++) mm[k][base+i] = d[8*i +: 8];
    endtask

    task automatic chk(string n, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, got, want);
        end
    endtask

    task automatic idle();
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    // Present a request at a negedge, hold it until Ready, record
    // what the DUT must answer, and return at the following negedge.
    task automatic issue(int k, bit r, bit w, logic [1:0] sz, bit u,
                         logic [31:0] a, logic [31:0] d);
        int g = 0;
        int e;
        exp_t x;
        sel = k; rd_req = r; wr_req = w;
        size = sz; uns = u; addr = a; wd = d;
        while (!(k == 1 ? rdy1 : rdy0)) begin
            @(negedge clk);
            g++;
            if (g > 16) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout dut%0d: got 0 want 1", k);
                break;
            end
        end
        e = cyc + 1;
        if ((r && w) || bad_req(sz, a)) begin
            if (k == 0) eq0.push_back(e); else eq1.push_back(e);
        end
        if (r && !w) begin
            x.data = ref_load(k, sz, u, a);
            x.cyc  = cyc + (k == 1 ? LAT1 : LAT0);
            if (k == 0) rq0.push_back(x); else rq1.push_back(x);
        end
        if (w && !r && !bad_req(sz, a)) ref_store(k, sz, a, d);
        @(negedge clk);
    endtask

    task automatic mon(int k, logic v, logic [31:0] d, logic e);
        exp_t x;
        int   c;
        while ((k == 0 ? rq0.size() : rq1.size()) > 0 &&
               (k == 0 ? rq0[0].cyc : rq1[0].cyc) < cyc) begin
            x = (k == 0) ? rq0.pop_front() : rq1.pop_front();
            checks++; errors++;
            $display("FAIL rdvalid_missing dut%0d: got none want %h @%0d",
                     k, x.data, x.cyc);
        end
        while ((k == 0 ? eq0.size() : eq1.size()) > 0 &&
               (k == 0 ? eq0[0] : eq1[0]) < cyc) begin
            c = (k == 0) ? eq0.pop_front() : eq1.pop_front();
            checks++; errors++;
            $display("FAIL addrerr_missing dut%0d: got none want @%0d", k, c);
        end
        if (v) begin
            checks++;
            if ((k == 0 ? rq0.size() : rq1.size()) == 0) begin
                errors++;
                $display("FAIL rdvalid_extra dut%0d: got %h @%0d want none",
                         k, d, cyc);
            end else begin
                x = (k == 0) ? rq0.pop_front() : rq1.pop_front();
                if (x.data !== d || x.cyc != cyc) begin
                    errors++;
                    $display("FAIL load dut%0d: got %h @%0d want %h @%0d",
                             k, d, cyc, x.data, x.cyc);
                end
            end
        end
        if (e) begin
            checks++;
            if ((k == 0 ? eq0.size() : eq1.size()) == 0) begin
                errors++;
                $display("FAIL addrerr_extra dut%0d: got 1 @%0d want 0",
                         k, cyc);
            end else begin
                c = (k == 0) ? eq0.pop_front() : eq1.pop_front();
                if (c != cyc) begin
                    errors++;
                    $display("FAIL addrerr dut%0d: got @%0d want @%0d",
                             k, cyc, c);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!in_rst) begin
            mon(0, rv0, rdo0, ae0);
            mon(1, rv1, rdo1, ae1);
            chk("l1_ready_high", 32'(rdy0), 32'd1);
        end
    end

    task automatic chk_reset(int k);
        chk($sformatf("rst_ready%0d", k), 32'(k ? rdy1 : rdy0), 32'd1);
        chk($sformatf("rst_rd%0d", k), k ? rdo1 : rdo0, 32'd0);
        chk($sformatf("rst_rdvalid%0d", k), 32'(k ? rv1 : rv0), 32'd0);
        chk($sformatf("rst_addrerr%0d", k), 32'(k ? ae1 : ae0), 32'd0);
    endtask

    task automatic directed(int k);
        issue(k, 0, 1, 2'd2, 0, 32'd88, 32'h1234_5678);
        issue(k, 1, 0, 2'd0, 1, 32'd88, 32'd0);
        issue(k, 1, 0, 2'd0, 1, 32'd89, 32'd0);
        issue(k, 1, 0, 2'd0, 1, 32'd91, 32'd0);
        issue(k, 1, 0, 2'd1, 1, 32'd90, 32'd0);
        issue(k, 0, 1, 2'd0, 0, 32'd92, 32'h0000_0080);
        issue(k, 1, 0, 2'd0, 0, 32'd92, 32'd0);
        issue(k, 1, 0, 2'd0, 1, 32'd92, 32'd0);
        issue(k, 1, 0, 2'd2, 0, 32'd92, 32'd0);
        issue(k, 0, 1, 2'd1, 0, 32'd89, 32'h0000_BEEF);
        issue(k, 1, 0, 2'd2, 0, 32'd88, 32'd0);
        issue(k, 1, 1, 2'd2, 0, 32'd88, 32'd0);
        issue(k, 1, 0, 2'd1, 0, 32'd89, 32'd0);
        issue(k, 1, 0, 2'd3, 0, 32'd96, 32'd0);
        issue(k, 1, 0, 2'd1, 0, 32'd1114, 32'd0);
        idle();
    endtask

    task automatic random_ops(int k, int n);
        logic [1:0] sz;
        int op;
        for (int i = 0; i < n; i++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            op = $urandom_range(0, 19);
            if (op < 9)
                issue(k, 1, 0, sz, 1'($urandom), $urandom, 32'd0);
            else if (op < 18)
                issue(k, 0, 1, sz, 1'($urandom), $urandom, $urandom);
            else if (op == 18)
                issue(k, 1, 1, sz, 1'($urandom), $urandom, $urandom);
            else begin
                idle();
                @(negedge clk);
            end
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        sel = 0;
        size = 2'd0; uns = 1'b0; addr = 32'd0; wd = 32'd0;
        idle();
        @(negedge clk);
        @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 256; w++)
                issue(k, 0, 1, 2'd2, 0, 32'(w*4), $urandom);
        idle();

        directed(0);
        directed(1);

        for (int i = 0; i < 4; i++)
            issue(0, 1, 0, 2'd2, 0, 32'(i*4), 32'd0);
        idle();
        repeat (3) @(negedge clk);

        issue(1, 1, 0, 2'd2, 0, 32'd0, 32'd0);
        sel = 1; rd_req = 1'b1; size = 2'd2; addr = 32'd4;
        chk("wait_ready_a", 32'(rdy1), 32'd0);
        @(negedge clk);
        chk("wait_ready_b", 32'(rdy1), 32'd0);
        @(negedge clk);
        chk("wait_ready_back", 32'(rdy1), 32'd1);
        chk("wait_rdvalid", 32'(rv1), 32'd1);
        issue(1, 1, 0, 2'd2, 0, 32'd4, 32'd0);
        idle();
        repeat (4) @(negedge clk);

        issue(1, 1, 0, 2'd2, 0, 32'd8, 32'd0);
        rst = 1'b1;
        sel = 0; wr_req = 1'b1; size = 2'd2; addr = 32'd64;
        wd = 32'hDEAD_BEEF;
        @(negedge clk);
        void'(rq1.pop_back());
        idle();
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        issue(1, 1, 0, 2'd2, 0, 32'd8, 32'd0);
        issue(0, 1, 0, 2'd2, 0, 32'd64, 32'd0);
        idle();

        random_ops(0, 300);
        random_ops(1, 300);

        repeat (8) @(negedge clk);
        chk("drain_rd0", 32'(rq0.size()), 32'd0);
        chk("drain_rd1", 32'(rq1.size()), 32'd0);
        chk("drain_err0", 32'(eq0.size()), 32'd0);
        chk("drain_err1", 32'(eq1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
